// File: rtl/key_counter_pkg.sv
// Shared constants and types for the DE2 up/down key counter.
package key_counter_pkg;

  // 20 ms of stable level at 50 MHz before a key change is believed.
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  localparam int COUNT_W = 4;
  localparam logic [COUNT_W-1:0] COUNT_MAX = 4'hF;
  localparam logic [COUNT_W-1:0] COUNT_MIN = 4'h0;

  // Active-low seven-segment glyphs, bit order gfedcba, indexed by digit 0..F.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'b0001110,  // F
    7'b0000110,  // E
    7'b0100001,  // d
    7'b1000110,  // C
    7'b0000011,  // b
    7'b0001000,  // A
    7'b0010000,  // 9
    7'b0000000,  // 8
    7'b1111000,  // 7
    7'b0000010,  // 6
    7'b0010010,  // 5
    7'b0011001,  // 4
    7'b0110000,  // 3
    7'b0100100,  // 2
    7'b1111001,  // 1
    7'b1000000   // 0
  };

  // What the counter does in a given cycle once both key pulses are known.
  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DOWN = 2'd2
  } step_e;

  typedef struct packed {
    logic underflow;
    logic overflow;
  } wrap_flags_t;

  function automatic logic [6:0] seg_of(input logic [COUNT_W-1:0] digit);
    return SEG_GLYPHS[digit];
  endfunction

  function automatic step_e step_of(input logic up, input logic down);
    step_e s;
    s = STEP_NONE;
    if (up && !down) begin
      s = STEP_UP;
    end else if (down && !up) begin
      s = STEP_DOWN;
    end
    return s;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Per-key conditioning: 2-flop synchronizer, stable-level debounce and a
// single-cycle pulse on the released->pressed transition of the stable level.
module key_debouncer
  import key_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_n,
  output logic press_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The level is accepted on the increment that would bring the count to
  // DEBOUNCE_CYCLES, so compare against the value one below it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  logic key_sync;
  assign key_sync = sync_q[1];

  // Synchronizer shift: raw pin enters bit 0, bit 1 is the only consumer.
  always_comb begin
    sync_d = {sync_q[0], key_raw_n};
  end

  // Debounce: count cycles of disagreement, accept the new level after enough.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (key_sync == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_d = key_sync;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Press pulse only on released (1) -> pressed (0); release is silent.
  always_comb begin
    press_d = stable_q & ~stable_d;
  end

  // State registers; reset leaves the key looking released with no pending work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/key_updown_counter_de2.sv
// Two-key modulo-16 up/down counter with wrap flags and a hex display.
module key_updown_counter_de2
  import key_counter_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       KEY_UP,
  input  logic       KEY_DOWN,
  output logic [3:0] LEDR,
  output logic [1:0] LEDG,
  output logic [6:0] HEX0
);

  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_int_n;

  logic press_up;
  logic press_down;

  logic [COUNT_W-1:0] count_q, count_d;
  wrap_flags_t        flags_q, flags_d;
  step_e              step;

  // Reset synchronizer: assert immediately, release two clocks later.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset synchronizer flops, cleared directly by the board reset.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_int_n = rst_sync_q[1];

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_up (
    .clk      (CLOCK_50),
    .rst_n    (rst_int_n),
    .key_raw_n(KEY_UP),
    .press_o  (press_up)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_down (
    .clk      (CLOCK_50),
    .rst_n    (rst_int_n),
    .key_raw_n(KEY_DOWN),
    .press_o  (press_down)
  );

  // Simultaneous up and down cancel out: neither count nor flags move.
  always_comb begin
    step = step_of(press_up, press_down);
  end

  // Count and wrap flags: a wrap sets its own flag, any other step clears both.
  always_comb begin
    count_d = count_q;
    flags_d = flags_q;
    unique case (step)
      STEP_UP: begin
        count_d = count_q + 4'd1;
        flags_d.overflow  = (count_q == COUNT_MAX);
        flags_d.underflow = 1'b0;
      end
      STEP_DOWN: begin
        count_d = count_q - 4'd1;
        flags_d.underflow = (count_q == COUNT_MIN);
        flags_d.overflow  = 1'b0;
      end
      default: begin
        count_d = count_q;
        flags_d = flags_q;
      end
    endcase
  end

  // Counter state, held at zero while the synchronized reset is active.
  always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
    if (!rst_int_n) begin
      count_q <= '0;
      flags_q <= '0;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  assign LEDR    = count_q;
  assign LEDG[0] = flags_q.overflow;
  assign LEDG[1] = flags_q.underflow;
  assign HEX0    = seg_of(count_q);

endmodule

// File: tb/tb_key_updown_counter_de2.sv
// Bench for key_updown_counter_de2 with a short debounce window.
module tb_key_updown_counter_de2;

  localparam int D = 4;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b1;
  logic       KEY_UP   = 1'b1;
  logic       KEY_DOWN = 1'b1;
  logic [3:0] LEDR;
  logic [1:0] LEDG;
  logic [6:0] HEX0;

  int n_chk  = 0;
  int n_pass = 0;

  key_updown_counter_de2 #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .KEY_UP  (KEY_UP),
    .KEY_DOWN(KEY_DOWN),
    .LEDR    (LEDR),
    .LEDG    (LEDG),
    .HEX0    (HEX0)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic logic [6:0] glyph(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;  10: return 7'h08; 11: return 7'h03;
      12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Reference model: a key level is believed once the last D synchronized
  // samples all disagree with it; a believed press moves the count one clock later.
  int m_count = 0;
  bit m_ovf = 0, m_unf = 0;
  bit m_stab [2];
  bit m_pend [2];
  bit m_hist [2][D+1];
  int m_hi = 0;

  task automatic m_clear();
    m_count = 0; m_ovf = 0; m_unf = 0;
    for (int k = 0; k < 2; k++) begin
      m_stab[k] = 1; m_pend[k] = 0;
      for (int j = 0; j <= D; j++) m_hist[k][j] = 1;
    end
  endtask

  task automatic m_step();
    bit raw [2];
    bit all_diff;
    raw[0] = KEY_UP; raw[1] = KEY_DOWN;
    if (m_pend[0] && !m_pend[1]) begin
      m_ovf = (m_count == 15); m_unf = 0; m_count = (m_count + 1) % 16;
    end else if (m_pend[1] && !m_pend[0]) begin
      m_unf = (m_count == 0); m_ovf = 0; m_count = (m_count + 15) % 16;
    end
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0;
      all_diff = 1;
      for (int j = 0; j < D; j++) if (m_hist[k][j] == m_stab[k]) all_diff = 0;
      if (all_diff) begin
        m_stab[k] = ~m_stab[k];
        if (m_stab[k] == 0) m_pend[k] = 1;
      end
      for (int j = 0; j < D; j++) m_hist[k][j] = m_hist[k][j+1];
      m_hist[k][D] = raw[k];
    end
  endtask

  initial m_clear();

  always @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      m_clear();
      m_hi = 0;
    end else begin
      if (m_hi < 100) m_hi++;
      if (m_hi <= 2) m_clear();
      else m_step();
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge CLOCK_50) begin
    check("mon_ledr", 32'(LEDR), 32'(m_count));
    check("mon_ledg", 32'(LEDG), 32'({m_unf, m_ovf}));
    check("mon_hex",  32'(HEX0), 32'(glyph(m_count)));
  end

  task automatic do_reset();
    @(negedge CLOCK_50);
    #2 RESET_N = 0;
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1;
    repeat (4) @(negedge CLOCK_50);
  endtask

  task automatic press(input bit up, input bit dn, input int hold);
    @(negedge CLOCK_50);
    if (up) KEY_UP = 0;
    if (dn) KEY_DOWN = 0;
    repeat (hold) @(negedge CLOCK_50);
    KEY_UP = 1; KEY_DOWN = 1;
    repeat (12) @(negedge CLOCK_50);
  endtask

  task automatic check_out(input string tag, input int cnt, input logic [1:0] flg);
    check({tag, "_ledr"}, 32'(LEDR), 32'(cnt));
    check({tag, "_ledg"}, 32'(LEDG), 32'(flg));
    check({tag, "_hex"},  32'(HEX0), 32'(glyph(cnt)));
  endtask

  initial begin
    int run [2];
    #1 RESET_N = 0;
    repeat (3) @(negedge CLOCK_50);
    check_out("reset", 0, 2'b00);
    check("reset_hex0", 32'(HEX0), 32'h40);
    RESET_N = 1;
    repeat (4) @(negedge CLOCK_50);

    // One clean press, update exactly at E+6.
    @(negedge CLOCK_50);
    KEY_UP = 0;
    repeat (6) @(posedge CLOCK_50);
    #1 check("e5_ledr", 32'(LEDR), 32'd0);
    @(posedge CLOCK_50);
    #1 check("e6_ledr", 32'(LEDR), 32'd1);
    repeat (13) @(negedge CLOCK_50);
    KEY_UP = 1;
    repeat (12) @(negedge CLOCK_50);
    check_out("one_up", 1, 2'b00);
    check("one_up_hex", 32'(HEX0), 32'h79);

    // Sixteen presses wrap to zero with overflow, one more clears it.
    do_reset();
    for (int i = 0; i < 16; i++) press(1, 0, 8);
    check_out("wrap16", 0, 2'b01);
    press(1, 0, 8);
    check_out("wrap17", 1, 2'b00);

    // Down from zero wraps to F with underflow.
    do_reset();
    press(0, 1, 20);
    check_out("down_wrap", 15, 2'b10);
    check("down_wrap_hex", 32'(HEX0), 32'h0E);

    // Bounce shorter than the window is ignored; a real hold counts once.
    for (int i = 0; i < 30; i++) begin
      @(negedge CLOCK_50);
      KEY_UP = ((i % 4) == 3);
    end
    KEY_UP = 1;
    repeat (12) @(negedge CLOCK_50);
    check_out("bounce", 15, 2'b10);
    press(1, 0, 40);
    check_out("bounce_hold", 0, 2'b01);

    // Simultaneous presses from 5 cancel.
    do_reset();
    for (int i = 0; i < 5; i++) press(1, 0, 6);
    press(1, 1, 20);
    check_out("both", 5, 2'b00);

    // Reset mid-debounce at count 9.
    for (int i = 0; i < 4; i++) press(1, 0, 6);
    check_out("at9", 9, 2'b00);
    @(negedge CLOCK_50);
    KEY_UP = 0;
    repeat (2) @(negedge CLOCK_50);
    #2 RESET_N = 0;
    #1 check_out("mid_rst", 0, 2'b00);
    @(negedge CLOCK_50);
    KEY_UP = 1;
    repeat (2) @(negedge CLOCK_50);
    RESET_N = 1;
    repeat (20) @(negedge CLOCK_50);
    check_out("after_rst", 0, 2'b00);

    // Key held low through reset release gives exactly one press.
    @(negedge CLOCK_50);
    #2 RESET_N = 0;
    KEY_DOWN = 0;
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1;
    repeat (30) @(negedge CLOCK_50);
    KEY_DOWN = 1;
    repeat (12) @(negedge CLOCK_50);
    check_out("held_rst", 15, 2'b10);

    // Random bouncing waveforms on both keys against the model.
    run[0] = 0; run[1] = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge CLOCK_50);
      if (run[0] == 0) begin KEY_UP = ~KEY_UP; run[0] = $urandom_range(1, 9); end
      else run[0]--;
      if (run[1] == 0) begin KEY_DOWN = ~KEY_DOWN; run[1] = $urandom_range(1, 9); end
      else run[1]--;
    end
    KEY_UP = 1; KEY_DOWN = 1;
    repeat (15) @(negedge CLOCK_50);
    check_out("rand_end", m_count, {m_unf, m_ovf});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/key_updown_counter_de2.md
KEY_UPDOWN_COUNTER_DE2 -- requirements
Module: key_updown_counter_de2

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000 (20 ms at 50 MHz), the number of consecutive stable cycles required to accept a key level change.
REQ-002 SHALL have port CLOCK_50  input  1  the single clock (50 MHz on the board); all flops on its rising edge.
REQ-003 SHALL have port RESET_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port KEY_UP  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to CLOCK_50, may bounce.
REQ-005 SHALL have port KEY_DOWN  input  1  raw pushbutton, same electrical rules as KEY_UP.
REQ-006 SHALL have port LEDR  output  4  current count, binary, LEDR[0] = LSB.
REQ-007 SHALL have port LEDG  output  2  LEDG[0] = overflow flag, LEDG[1] = underflow flag.
REQ-008 SHALL have port HEX0  output  7  count as a hex digit on an active-low seven-segment display, bit order gfedcba.

Function
REQ-009 SHALL pass each key through a 2-flop synchronizer before any other use.
REQ-010 SHALL keep a debounced stable level per key and a debounce counter of width $clog2(DEBOUNCE_CYCLES+1).
REQ-011 SHALL clear the debounce counter in any cycle where the synchronized level equals the stable level, and otherwise increment it.
REQ-012 SHALL set the stable level to the synchronized level, and clear the counter, in the cycle the counter reaches DEBOUNCE_CYCLES.
REQ-013 SHALL generate a one-cycle press pulse when the stable level changes 1->0; a 0->1 change (release) SHALL produce no pulse.
REQ-014 SHALL give a clean press this timing: first sampled low at edge E; stable level changes at edge E+1+DEBOUNCE_CYCLES; count register updates at edge E+2+DEBOUNCE_CYCLES.
REQ-015 SHALL treat a key held indefinitely as one press; there is no auto-repeat.
REQ-016 SHALL increment the count modulo 16 on an up pulse alone; 15 -> 0 SHALL set overflow and clear underflow.
REQ-017 SHALL decrement the count modulo 16 on a down pulse alone; 0 -> 15 SHALL set underflow and clear overflow.
REQ-018 SHALL clear both flags on a non-wrapping accepted step; flags otherwise hold their value.
REQ-019 SHALL, when up and down pulses occur in the same cycle, leave the count and both flags unchanged.
REQ-020 SHALL drive HEX0 combinationally from the count using the standard 0-F glyphs: 0 = 1000000, 1 = 1111001, 8 = 0000000, F = 0001110.
REQ-021 SHALL ignore bounce pulses shorter than DEBOUNCE_CYCLES cycles completely.

Reset
REQ-022 SHALL assert reset asynchronously and deassert it synchronously through an internal 2-flop reset synchronizer.
REQ-023 SHALL, while reset is active, drive: count 0, both flags 0, synchronizer flops 1, stable levels 1 (released), debounce counters 0; LEDR = 0000, LEDG = 00, HEX0 = 1000000.
REQ-024 SHALL, for a key held low through reset release, produce exactly one press on that key after normal debounce.
REQ-025 SHALL abort any in-progress debounce when reset is asserted mid-operation; no pending press survives reset.

Structure
REQ-026 SHALL place the 16-entry seven-segment glyph constants and the default debounce value in shared package key_counter_pkg.
REQ-027 SHALL implement synchronizer, debounce and press-pulse logic in sub-module key_debouncer, instantiated once per key.
REQ-028 SHALL keep the count, flags, reset synchronizer and HEX decode in the top module.

Verification (DEBOUNCE_CYCLES = 4 in simulation)
REQ-029 SHALL check: reset, then one clean KEY_UP press held for 20 cycles -> LEDR = 0001, HEX0 = 1111001, LEDG = 00, with the update exactly at edge E+6.
REQ-030 SHALL check: 16 clean KEY_UP presses -> LEDR = 0000 with LEDG[0] = 1; one further KEY_UP press -> LEDR = 0001, LEDG = 00.
REQ-031 SHALL check: from count 0, one KEY_DOWN press -> LEDR = 1111, HEX0 = 0001110, LEDG[1] = 1.
REQ-032 SHALL check: KEY_UP toggling low 3 cycles / high 1 cycle for 30 cycles, then released -> count unchanged; then held low -> exactly +1.
REQ-033 SHALL check: both keys pressed on the same edge, each held 20 cycles, from count 5 -> LEDR stays 0101 and flags stay unchanged.
REQ-034 SHALL check: RESET_N pulsed low mid-debounce at count 9 -> outputs at their reset values immediately (LEDR = 0000), no count change after release.
